// File: rtl/rtc_mcu_bus_sync_decoder_if.sv
// rtl/rtc_mcu_bus_sync_decoder_if.sv - MCU bus strobes in, qualified decode vectors out
interface rtc_mcu_bus_sync_decoder_if;
  logic        i_mcu_cs;
  logic        i_mcu_r_neg_w;
  logic [4:0]  i_mcu_addr;
  logic        o_cs;
  logic        o_r_neg_w;
  logic [30:0] rd_dec_addr;
  logic [30:0] wr_dec_addr;
  logic        o_addr_err;
  logic        o_glitch;

  modport master (
    output i_mcu_cs, i_mcu_r_neg_w, i_mcu_addr,
    input  o_cs, o_r_neg_w, rd_dec_addr, wr_dec_addr, o_addr_err, o_glitch
  );

  modport slave (
    input  i_mcu_cs, i_mcu_r_neg_w, i_mcu_addr,
    output o_cs, o_r_neg_w, rd_dec_addr, wr_dec_addr, o_addr_err, o_glitch
  );
endinterface

// File: rtl/rtc_mcu_bus_sync_decoder.sv
// rtl/rtc_mcu_bus_sync_decoder.sv - resynchronise MCU strobes, filter cs, latch and decode one access
module rtc_mcu_bus_sync_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input logic                       i_sys_clk,
  input logic                       i_reset,
  rtc_mcu_bus_sync_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, ACTIVE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
  logic       rnw_l_q, rnw_l_d;
  logic [4:0] addr_l_q, addr_l_d;
  logic        o_cs_q, o_cs_d;
  logic        o_r_neg_w_q, o_r_neg_w_d;
  logic [30:0] rd_q, rd_d;
  logic [30:0] wr_q, wr_d;
  logic        addr_err_q, addr_err_d;
  logic        glitch_q, glitch_d;
  logic [30:0] onehot;

  logic       cs_s, rnw_s;
  logic [4:0] addr_s;
  assign {cs_s, rnw_s, addr_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync_q      <= '0;
      rnw_l_q     <= 1'b0;
      addr_l_q    <= '0;
      o_cs_q      <= 1'b0;
      o_r_neg_w_q <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      addr_err_q  <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      rnw_l_q     <= rnw_l_d;
      addr_l_q    <= addr_l_d;
      o_cs_q      <= o_cs_d;
      o_r_neg_w_q <= o_r_neg_w_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_err_q  <= addr_err_d;
      glitch_q    <= glitch_d;
    end
  end

  // Every bus bit runs through its own chain; element 0 is the first capture stage.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], {bus.i_mcu_cs, bus.i_mcu_r_neg_w, bus.i_mcu_addr}};
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnw_l_d  = rnw_l_q;
    addr_l_d = addr_l_q;
    case (state_q)
      IDLE: begin
        if (cs_s) begin
          if (FILTER_LEN == 1) begin
            state_d  = ACTIVE;
            rnw_l_d  = rnw_s;
            addr_l_d = addr_s;
          end else begin
            state_d = QUAL;
            cnt_d   = 4'd1;
          end
        end
      end
      QUAL: begin
        if (!cs_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (({1'b0, cnt_q} + 5'd1) == 5'(FILTER_LEN)) begin
          state_d  = ACTIVE;
          cnt_d    = '0;
          rnw_l_d  = rnw_s;
          addr_l_d = addr_s;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACTIVE: begin
        if (!cs_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs look ahead to the next state so they register in the same edge as the transition.
  always_comb begin
    o_cs_d      = (state_d == ACTIVE);
    o_r_neg_w_d = o_cs_d && rnw_l_d;
    addr_err_d  = o_cs_d && (addr_l_d == 5'd31);
    onehot      = (addr_l_d == 5'd31) ? 31'd0 : (31'd1 << addr_l_d);
    rd_d        = (o_cs_d && rnw_l_d)  ? onehot : 31'd0;
    wr_d        = (o_cs_d && !rnw_l_d) ? onehot : 31'd0;
    glitch_d    = (state_q == QUAL) && !cs_s;
  end

  assign bus.o_cs        = o_cs_q;
  assign bus.o_r_neg_w   = o_r_neg_w_q;
  assign bus.rd_dec_addr = rd_q;
  assign bus.wr_dec_addr = wr_q;
  assign bus.o_addr_err  = addr_err_q;
  assign bus.o_glitch    = glitch_q;
endmodule

// File: doc/rtc_mcu_bus_sync_decoder.md
# rtc_mcu_bus_sync_decoder

Front end of the CAN controller's Microcontroller Interface, directly upstream of the read/write one-pulse decoder. It takes the asynchronous microcontroller bus strobes (chip select, read/write direction, 5-bit register address) and resynchronises them into `i_sys_clk`. It rejects chip-select glitches and latches one address/direction per access. It then drives registered, one-hot read and write decode vectors plus qualified `cs`/`r_neg_w` to the pulse decoder.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of every synchroniser chain; legal range ≥2.
- `FILTER_LEN`, default 2: number of consecutive synchronised high samples of chip select required to accept an access; legal range 1–15.
- `i_sys_clk`, input, 1: system clock; the only clock.
- `i_reset`, input, 1: reset; asynchronous, active-high.
- `i_mcu_cs`, input, 1: asynchronous chip select from the MCU, active-high.
- `i_mcu_r_neg_w`, input, 1: asynchronous direction; 1 = read, 0 = write.
- `i_mcu_addr`, input, 5: asynchronous register address; 0–30 valid, 31 invalid.
- `o_cs`, output, 1: qualified chip select; feeds the pulse decoder `i_cs`.
- `o_r_neg_w`, output, 1: latched direction; forced to 0 whenever `o_cs` = 0.
- `rd_dec_addr`, output, 31: one-hot read select; bit n set when a read of address n is active.
- `wr_dec_addr`, output, 31: one-hot write select; bit n set when a write of address n is active.
- `o_addr_err`, output, 1: level; high while an accepted access targets address 31.
- `o_glitch`, output, 1: one-cycle pulse when a chip-select assertion is rejected by the filter.

## Operation
- **Synchronisers:** `i_mcu_cs`, `i_mcu_r_neg_w` and each bit of `i_mcu_addr` pass through independent `SYNC_STAGES`-deep chains. The synchronised results are `cs_s`, `rnw_s` and `addr_s`.
- **Bus rule:** the MCU holds address and direction stable from before `cs` rises until after `cs` falls. Sampling happens only at qualification.
- **FSM states:** IDLE, QUAL, ACTIVE. A 4-bit counter `cnt` counts consecutive high `cs_s` samples.
- **IDLE:**
  - `cs_s` = 0: stay in IDLE.
  - `cs_s` = 1 and `FILTER_LEN` = 1: go to ACTIVE and latch `addr_s`/`rnw_s`.
  - `cs_s` = 1 and `FILTER_LEN` > 1: go to QUAL with `cnt` = 1.
- **QUAL:**
  - `cs_s` = 0: go to IDLE and pulse `o_glitch` for 1 cycle.
  - `cs_s` = 1 and `cnt`+1 = `FILTER_LEN`: go to ACTIVE and latch `addr_s`/`rnw_s`.
  - Otherwise: increment `cnt`.
- **ACTIVE:**
  - `cs_s` = 1: stay in ACTIVE. Changes on `addr_s`/`rnw_s` are ignored.
  - `cs_s` = 0: go to IDLE.
- **Outputs are registered** and computed from next state plus the latched values:
  - ACTIVE: `o_cs` = 1 and `o_r_neg_w` = latched direction.
  - ACTIVE with latched read: `rd_dec_addr` = 1 << addr and `wr_dec_addr` = 0.
  - ACTIVE with latched write: `wr_dec_addr` = 1 << addr and `rd_dec_addr` = 0.
  - ACTIVE with address 31: both vectors 0 and `o_addr_err` = 1; `o_cs` is still asserted.
  - IDLE and QUAL: all outputs 0, except `o_glitch` as above.
- **Vector invariants:** at most one bit is set across both vectors, and never both vectors at once.
- **Direction changes:** a direction change requires `cs` to deassert, giving a new access. `o_r_neg_w` = 0 while idle, so the downstream decoder's done states can return to idle.

## Timing
- **Reset:** all synchroniser flops, state (IDLE), `cnt` and all outputs are 0 immediately on `i_reset`, with no clock needed.
- **Reset mid-access:** outputs drop to 0 asynchronously. If `cs` is still high after release, it is treated as a new access and passes full synchronisation and qualification.
- **Assert latency:** for `i_mcu_cs` rising before edge k, outputs are valid after edge k + `SYNC_STAGES` + `FILTER_LEN` − 1. Default: k+3.
- **Release latency:** for `i_mcu_cs` falling before edge m, outputs are 0 after edge m + `SYNC_STAGES`. Default: m+2.
- **Minimum accepted pulse:** `FILTER_LEN` cycles of synchronised high. Shorter pulses produce `o_glitch` only, with no `o_cs`.
- **Back-to-back accesses:** `cs` low for 1 synchronised sample suffices. ACTIVE → IDLE → QUAL/ACTIVE with no extra dead cycle.
- **Throughput:** one access per `cs` assertion.

## Test plan
- **Read, address 5, defaults:** `cs`=1, `rnw`=1, `addr`=5 held 8 cycles → `o_cs`=1, `o_r_neg_w`=1, `rd_dec_addr`=0x00000020, `wr_dec_addr`=0, valid 3 edges after `cs` rises; all 0 two edges after `cs` falls.
- **Write, address 30:** `cs`=1, `rnw`=0, `addr`=30 → `wr_dec_addr`=0x40000000, `rd_dec_addr`=0, `o_r_neg_w`=0.
- **Glitch:** `cs` high for exactly 1 synchronised cycle, `FILTER_LEN`=2 → `o_glitch` pulses once; `o_cs` and both vectors stay 0.
- **Invalid address:** `addr`=31, read → `o_cs`=1, both vectors 0, `o_addr_err`=1 until `cs` falls.
- **Mid-access address change:** `addr` changes from 3 to 7 while in ACTIVE → `rd_dec_addr` stays 0x00000008. Then drop `cs` 1 cycle and reassert with write → `wr_dec_addr`=0x00000080.
- **Reset mid-access:** assert `i_reset` while ACTIVE → all outputs 0 before the next edge. Release with `cs` held → outputs return 3 edges later.
